// File: rtl/fc_mac_sequencer.sv
// Operand sequencer and accumulator around the FC-layer Booth multiplier.
// Streams LEN (x,w) pairs, accumulates the products onto a bias, and emits one ReLU'd, saturated neuron value.
module fc_mac_sequencer #(
  parameter int N     = 5,
  parameter int LEN   = 4,
  parameter int ACC_W = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic [2*N-1:0] bias_i,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  logic [N-1:0]   in_x_i,
  input  logic [N-1:0]   in_w_i,
  output logic [N-1:0]   mul_m_o,
  output logic [N-1:0]   mul_r_o,
  output logic           mul_en_o,
  input  logic [2*N-1:0] mul_result_i,
  input  logic           mul_finish_i,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [2*N-1:0] out_data_o,
  output logic           busy_o
);

  localparam int CNT_W = $clog2(LEN + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);
  localparam logic [2*N-1:0] OUT_MAX = {1'b0, {(2*N-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(OUT_MAX);

  typedef enum logic [2:0] {IDLE, LOAD, MUL, GAP, POST, OUT} state_t;

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [N-1:0]             mul_m_q, mul_m_d, mul_r_q, mul_r_d;
  logic                     out_valid_q, out_valid_d;
  logic [2*N-1:0]           out_data_q, out_data_d;

  logic signed [ACC_W-1:0]  bias_ext, prod_ext;

  assign bias_ext = {{(ACC_W-2*N){bias_i[2*N-1]}}, bias_i};
  assign prod_ext = {{(ACC_W-2*N){mul_result_i[2*N-1]}}, mul_result_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      mul_m_q     <= '0;
      mul_r_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      mul_m_q     <= mul_m_d;
      mul_r_q     <= mul_r_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    mul_m_d     = mul_m_q;
    mul_r_d     = mul_r_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      IDLE: if (start_i) begin
        acc_d   = bias_ext;
        cnt_d   = '0;
        state_d = LOAD;
      end
      LOAD: if (in_valid_i) begin
        mul_m_d = in_w_i;
        mul_r_d = in_x_i;
        state_d = MUL;
      end
      // Product is only trusted while the multiplier is enabled.
      MUL: if (mul_finish_i) begin
        acc_d   = acc_q + prod_ext;
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == LAST) ? POST : GAP;
      end
      GAP: state_d = LOAD;
      POST: begin
        if (acc_q[ACC_W-1])     out_data_d = '0;
        else if (acc_q > SAT_MAX) out_data_d = OUT_MAX;
        else                    out_data_d = acc_q[2*N-1:0];
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: if (out_ready_i) begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready_o  = (state_q == LOAD);
  assign mul_en_o    = (state_q == MUL);
  assign busy_o      = (state_q != IDLE);
  assign mul_m_o     = mul_m_q;
  assign mul_r_o     = mul_r_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

endmodule
